// File: rtl/nios_system_nios2_mult_unit_if.sv
// Operand/result handshake bundle for the Nios II multiply unit.
// master = operand source and result consumer; slave = the multiply unit.
interface nios_system_nios2_mult_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;

  modport master (
    output in_valid, op, src1, src2, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, op, src1, src2, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/nios_system_nios2_mult_unit.sv
// Pipelined WIDTH x WIDTH multiplier returning the low word (MUL) or the high word with
// per-opcode operand signedness (MULXUU/MULXSU/MULXSS), with valid/ready flow control and flush.
module nios_system_nios2_mult_unit #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input logic                          clk,
  input logic                          reset_n,
  input logic                          flush,
  nios_system_nios2_mult_unit_if.slave bus
);

  localparam int unsigned PW = 2 * WIDTH;

  logic             advance;
  logic             accept;
  logic             a_sign;
  logic             b_sign;
  logic [PW-1:0]    a_ext;
  logic [PW-1:0]    b_ext;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] word;

  logic [STAGES-1:0] v_q, v_d;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];

  // Extending both operands to 2*WIDTH makes a plain modular product bit-exact
  // for every signedness combination.
  always_comb begin
    a_sign = bus.op[1] & bus.src1[WIDTH-1];
    b_sign = (bus.op == 2'b11) & bus.src2[WIDTH-1];
    a_ext  = {{WIDTH{a_sign}}, bus.src1};
    b_ext  = {{WIDTH{b_sign}}, bus.src2};
    prod   = a_ext * b_ext;
    word   = (bus.op == 2'b00) ? prod[WIDTH-1:0] : prod[PW-1:WIDTH];
  end

  always_comb begin
    advance = ~v_q[STAGES-1] | bus.out_ready;
    accept  = bus.in_valid & advance & ~flush;
  end

  assign bus.in_ready  = advance & ~flush;
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.result    = data_q[STAGES-1];

  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    if (advance) begin
      v_d[0] = accept;
      if (accept) begin
        data_d[0] = word;
      end
      for (int i = 1; i < int'(STAGES); i++) begin
        v_d[i]    = v_q[i-1];
        data_d[i] = data_q[i-1];
      end
    end
    // Flush empties the valid chain only; data is left as-is.
    if (flush) begin
      v_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q <= '0;
      for (int i = 0; i < int'(STAGES); i++) begin
        data_q[i] <= '0;
      end
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

endmodule

// File: tb/tb_nios_system_nios2_mult_unit.sv
// Directed bench for the multiply unit: opcode/signedness vectors, back-pressure,
// flush, asynchronous reset, and a randomised stream checked against a product model.
module tb_nios_system_nios2_mult_unit;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned STAGES = 2;

  localparam logic [1:0] OpMul   = 2'b00;
  localparam logic [1:0] OpMulUu = 2'b01;
  localparam logic [1:0] OpMulSu = 2'b10;
  localparam logic [1:0] OpMulSs = 2'b11;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic flush   = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nios_system_nios2_mult_unit_if #(.WIDTH(WIDTH)) bus ();

  nios_system_nios2_mult_unit #(
    .WIDTH (WIDTH),
    .STAGES(STAGES)
  ) u_dut (
    .clk    (clk),
    .reset_n(reset_n),
    .flush  (flush),
    .bus    (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference built on 64-bit integer arithmetic.
  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    longint     ia;
    longint     ib;
    logic [63:0] p;
    ia = o[1] ? longint'($signed(a)) : longint'({32'b0, a});
    ib = (o == OpMulSs) ? longint'($signed(b)) : longint'({32'b0, b});
    p  = 64'(ia * ib);
    return (o == OpMul) ? p[31:0] : p[63:32];
  endfunction

  // One isolated transaction: checks acceptance, 2-cycle latency and the result word.
  task automatic single(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.op        = o;
    bus.src1      = a;
    bus.src2      = b;
    bus.out_ready = 1'b1;
    #1 check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({tag, "_lat"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
    check(tag, bus.result, exp);
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] exp_res;
    int          sent_n;
    int          idx;
    bit          accepted;

    bus.in_valid  = 1'b0;
    bus.op        = OpMul;
    bus.src1      = '0;
    bus.src2      = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_vld", 32'(bus.out_valid), 32'd0);
    check("rst_res", bus.result, 32'd0);
    check("rst_rdy", 32'(bus.in_ready), 32'd1);

    single("mul",       OpMul,   32'h0001_0003, 32'h0002_0005, 32'h000B_000F);
    single("mulxuu",    OpMulUu, 32'h0001_0003, 32'h0002_0005, 32'h0000_0002);
    single("sgn_ss",    OpMulSs, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
    single("sgn_su",    OpMulSu, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
    single("sgn_uu",    OpMulUu, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);
    single("sgn_mul",   OpMul,   32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE);
    single("sgn_su_sw", OpMulSu, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001);
    single("min_ss",    OpMulSs, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    single("min_mul",   OpMul,   32'h8000_0000, 32'h8000_0000, 32'h0000_0000);
    single("max_uu",    OpMulUu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    // Back-pressure: k*3 for k=1..6, out_ready low on cycles 3..5.
    @(negedge clk);
    sent_n = 0;
    idx    = 0;
    for (int c = 0; c < 12; c++) begin
      if (c != 0) @(negedge clk);
      bus.out_ready = !(c >= 3 && c <= 5);
      bus.in_valid  = (sent_n < 6);
      bus.op        = OpMul;
      bus.src1      = 32'(sent_n + 1);
      bus.src2      = 32'd3;
      #1;
      check($sformatf("bp_rdy%0d", c), 32'(bus.in_ready), 32'(!(c >= 3 && c <= 5)));
      check($sformatf("bp_vld%0d", c), 32'(bus.out_valid), 32'(c >= 2 && c <= 10));
      if (c >= 2 && c <= 10) begin
        exp_res = 32'(3 * (idx + 1));
        check($sformatf("bp_res%0d", c), bus.result, exp_res);
        if (bus.out_ready) idx++;
      end
      if (bus.in_valid && !(c >= 3 && c <= 5)) sent_n++;
    end
    check("bp_count", 32'(idx), 32'd6);

    // Flush with two in flight; the flush-cycle input must not be taken.
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.op        = OpMul;
    bus.src1      = 32'd5;
    bus.src2      = 32'd7;
    @(negedge clk);
    bus.src1 = 32'd6;
    @(negedge clk);
    flush    = 1'b1;
    bus.src1 = 32'd9;
    #1;
    check("fl_rdy", 32'(bus.in_ready), 32'd0);
    check("fl_vld", 32'(bus.out_valid), 32'd1);
    check("fl_res", bus.result, 32'd35);
    @(negedge clk);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("fl_vld_after", 32'(bus.out_valid), 32'd0);
    check("fl_rdy_after", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check("fl_vld_after2", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset between edges while a result is held.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.src1     = 32'h0000_1234;
    bus.src2     = 32'h0000_0010;
    @(negedge clk);
    bus.src1 = 32'd2;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("ar_vld_pre", 32'(bus.out_valid), 32'd1);
    check("ar_res_pre", bus.result, 32'h0001_2340);
    #2 reset_n = 1'b0;
    #1;
    check("ar_vld", 32'(bus.out_valid), 32'd0);
    check("ar_res", bus.result, 32'd0);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("ar_vld_rel", 32'(bus.out_valid), 32'd0);
    check("ar_rdy_rel", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check("ar_vld_rel2", 32'(bus.out_valid), 32'd0);

    // Random stream with random back-pressure, checked in order against the model.
    sent_n   = 0;
    accepted = 1'b0;
    bus.in_valid = 1'b0;
    for (int c = 0; c < 2000 && (sent_n < 200 || q.size() > 0); c++) begin
      @(negedge clk);
      if (!bus.in_valid || accepted) begin
        bus.in_valid = (sent_n < 200) && ($urandom_range(0, 4) != 0);
        bus.op       = 2'($urandom_range(0, 3));
        bus.src1     = $urandom;
        bus.src2     = $urandom;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      check("rnd_rdy", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) check("rnd_extra", 32'(bus.out_valid), 32'd0);
        else check("rnd_res", bus.result, q.pop_front());
      end
      accepted = bus.in_valid && bus.in_ready;
      if (accepted) begin
        q.push_back(ref_mul(bus.op, bus.src1, bus.src2));
        sent_n++;
      end
    end
    check("rnd_sent", 32'(sent_n), 32'd200);
    check("rnd_drain", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
